// File: rtl/wb_grf.sv
// MIPS write-back stage: decodes the W-stage instruction and commits its result to a 32x32 GRF.
// Two combinational read ports with optional write-before-read bypass, plus a retired-instruction counter.
module wb_grf #(
  parameter int BYPASS = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ir_w,
  input  logic [31:0]      pc4_w,
  input  logic [31:0]      aluc_w,
  input  logic [31:0]      dm_w,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  output logic [31:0]      rd1,
  output logic [31:0]      rd2,
  output logic             wb_en,
  output logic [4:0]       wb_addr,
  output logic [31:0]      wb_data,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [7:0]  mem_byte;
  logic [15:0] mem_half;
  logic [31:0] link_addr;
  logic        dec_wr;
  logic [4:0]  dec_addr;
  logic [31:0] dec_data;
  logic [31:0] regs [0:31];
  logic        unused_ir;

  assign op        = ir_w[31:26];
  assign fn        = ir_w[5:0];
  assign rt        = ir_w[20:16];
  assign rd        = ir_w[15:11];
  assign unused_ir = ^{ir_w[25:21], ir_w[10:6]};
  assign link_addr = pc4_w + 32'd4;
  assign mem_byte  = dm_w[{aluc_w[1:0], 3'b000} +: 8];
  assign mem_half  = aluc_w[1] ? dm_w[31:16] : dm_w[15:0];

  always_comb begin
    dec_wr   = 1'b0;
    dec_addr = 5'd0;
    dec_data = 32'd0;
    unique case (op)
      OP_RTYPE: begin
        if (fn == FN_JALR) begin
          dec_wr   = 1'b1;
          dec_addr = rd;
          dec_data = link_addr;
        end else if (fn != FN_JR) begin
          dec_wr   = 1'b1;
          dec_addr = rd;
          dec_data = aluc_w;
        end
      end
      OP_ORI, OP_LUI, OP_ADDIU: begin
        dec_wr   = 1'b1;
        dec_addr = rt;
        dec_data = aluc_w;
      end
      OP_LW: begin
        dec_wr   = 1'b1;
        dec_addr = rt;
        dec_data = dm_w;
      end
      OP_LB, OP_LBU: begin
        dec_wr   = 1'b1;
        dec_addr = rt;
        dec_data = (op == OP_LB) ? {{24{mem_byte[7]}}, mem_byte} : {24'd0, mem_byte};
      end
      OP_LH, OP_LHU: begin
        dec_wr   = 1'b1;
        dec_addr = rt;
        dec_data = (op == OP_LH) ? {{16{mem_half[15]}}, mem_half} : {16'd0, mem_half};
      end
      OP_JAL: begin
        dec_wr   = 1'b1;
        dec_addr = 5'd31;
        dec_data = link_addr;
      end
      default: begin
        dec_wr = 1'b0;
      end
    endcase
  end

  // A decoded write to $0 is reported as no write at all: address and data both zero.
  assign wb_en   = dec_wr && (dec_addr != 5'd0);
  assign wb_addr = wb_en ? dec_addr : 5'd0;
  assign wb_data = wb_en ? dec_data : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      retire_cnt <= '0;
    else if (ir_w != 32'd0)
      retire_cnt <= retire_cnt + CNT_W'(1);
  end

  always_comb begin
    if (ra1 == 5'd0)
      rd1 = 32'd0;
    else if ((BYPASS != 0) && wb_en && (ra1 == wb_addr))
      rd1 = wb_data;
    else
      rd1 = regs[ra1];
  end

  always_comb begin
    if (ra2 == 5'd0)
      rd2 = 32'd0;
    else if ((BYPASS != 0) && wb_en && (ra2 == wb_addr))
      rd2 = wb_data;
    else
      rd2 = regs[ra2];
  end

endmodule
